// File: rtl/ahb_resp_sel_ctrl.sv
// Address-phase slave decode, registered data-phase response select and
// built-in default slave (two-cycle ERROR) with a saturating decode-error counter.
module ahb_resp_sel_ctrl #(
  parameter int unsigned                      CHANNEL_NUM = 1,
  parameter int unsigned                      ADDR_W      = 32,
  parameter logic [CHANNEL_NUM*ADDR_W-1:0]    SLV_BASE    = '0,
  parameter logic [CHANNEL_NUM*ADDR_W-1:0]    SLV_MASK    = '1
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [ADDR_W-1:0]      HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  input  logic                   err_clr,
  output logic [CHANNEL_NUM-1:0] hsel_addr,
  output logic [CHANNEL_NUM-1:0] resp_sel,
  output logic                   def_active,
  output logic                   def_hreadyout,
  output logic                   def_hresp,
  output logic [7:0]             err_cnt
);

  typedef enum logic [1:0] {
    DEF_OK   = 2'd0,
    DEF_ERR1 = 2'd1,
    DEF_ERR2 = 2'd2
  } def_state_t;

  def_state_t state_q, state_d;
  logic       hit;
  logic       unmapped;

  // Lowest index wins on overlapping windows, keeping hsel_addr one-hot or zero.
  always_comb begin
    hsel_addr = '0;
    hit       = 1'b0;
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      if (!hit && ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                   (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]))) begin
        hsel_addr[i] = 1'b1;
        hit          = 1'b1;
      end
    end
  end

  assign unmapped = (hsel_addr == '0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      resp_sel   <= '0;
      def_active <= 1'b0;
    end else if (HREADY) begin
      resp_sel   <= hsel_addr;
      def_active <= unmapped;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= DEF_OK;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    def_hreadyout = 1'b1;
    def_hresp     = 1'b0;
    case (state_q)
      DEF_ERR1: begin
        def_hreadyout = 1'b0;
        def_hresp     = 1'b1;
        state_d       = DEF_ERR2;
      end
      default: begin
        def_hresp = (state_q == DEF_ERR2);
        if (HREADY) state_d = (HTRANS[1] && unmapped) ? DEF_ERR1 : DEF_OK;
      end
    endcase
  end

  // Every entry into DEF_ERR1 is a fresh decode error; clear beats increment.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                                 err_cnt <= '0;
    else if (err_clr)                             err_cnt <= '0;
    else if (state_d == DEF_ERR1 && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
  end

endmodule

// File: tb/tb_ahb_resp_sel_ctrl.sv
// Directed bench for ahb_resp_sel_ctrl: two slaves at 0x0xxx_xxxx and 0x1xxx_xxxx,
// HREADY modelled as the mux output (default slave or mapped-slave ready).
module tb_ahb_resp_sel_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        err_clr;
  logic        slave_ready;
  logic [1:0]  hsel_addr;
  logic [1:0]  resp_sel;
  logic        def_active;
  logic        def_hreadyout;
  logic        def_hresp;
  logic [7:0]  err_cnt;

  int checks = 0;
  int fails  = 0;

  always #5 HCLK = ~HCLK;

  assign HREADY = def_active ? def_hreadyout : slave_ready;

  ahb_resp_sel_ctrl #(
    .CHANNEL_NUM (2),
    .ADDR_W      (32),
    .SLV_BASE    ({32'h1000_0000, 32'h0000_0000}),
    .SLV_MASK    ({32'hF000_0000, 32'hF000_0000})
  ) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .HADDR         (HADDR),
    .HTRANS        (HTRANS),
    .HREADY        (HREADY),
    .err_clr       (err_clr),
    .hsel_addr     (hsel_addr),
    .resp_sel      (resp_sel),
    .def_active    (def_active),
    .def_hreadyout (def_hreadyout),
    .def_hresp     (def_hresp),
    .err_cnt       (err_cnt)
  );

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; HADDR = '0; HTRANS = 2'b00; err_clr = 1'b0; slave_ready = 1'b1;
    step(); step();
    checks++; if (resp_sel !== 2'b00) begin fails++; $display("FAIL rst_resp_sel got %b exp 00", resp_sel); end
    checks++; if (def_active !== 1'b0) begin fails++; $display("FAIL rst_def_active got %b exp 0", def_active); end
    checks++; if ({def_hreadyout, def_hresp} !== 2'b10) begin fails++; $display("FAIL rst_def_resp got %b exp 10", {def_hreadyout, def_hresp}); end
    checks++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL rst_err_cnt got %0d exp 0", err_cnt); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();
  endtask

  task automatic test_mapped_stall();
    HADDR = 32'h1000_0040; HTRANS = 2'b10;
    #1;
    checks++; if (hsel_addr !== 2'b10) begin fails++; $display("FAIL map_hsel got %b exp 10", hsel_addr); end
    step();
    // slave inserts 3 wait states; a new unmapped IDLE address must not be captured
    slave_ready = 1'b0; HADDR = 32'h3000_0000; HTRANS = 2'b00;
    #1;
    checks++; if (hsel_addr !== 2'b00) begin fails++; $display("FAIL unmap_hsel got %b exp 00", hsel_addr); end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) slave_ready = 1'b1;
      checks++; if (resp_sel !== 2'b10 || def_active !== 1'b0) begin fails++; $display("FAIL stall_hold%0d got %b/%b exp 10/0", i, resp_sel, def_active); end
      checks++; if ({def_hreadyout, def_hresp} !== 2'b10) begin fails++; $display("FAIL stall_fsm%0d got %b exp 10", i, {def_hreadyout, def_hresp}); end
      if (i < 3) step();
    end
    step();
    checks++; if (resp_sel !== 2'b00 || def_active !== 1'b1) begin fails++; $display("FAIL idle_unmap_sel got %b/%b exp 00/1", resp_sel, def_active); end
    checks++; if ({def_hreadyout, def_hresp} !== 2'b10) begin fails++; $display("FAIL idle_unmap_resp got %b exp 10", {def_hreadyout, def_hresp}); end
    checks++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL idle_unmap_cnt got %0d exp 0", err_cnt); end
  endtask

  task automatic test_unmapped();
    HADDR = 32'h2000_0000; HTRANS = 2'b10;
    step();
    HADDR = 32'h0000_0000; HTRANS = 2'b00;
    checks++; if ({def_active, def_hreadyout, def_hresp} !== 3'b101) begin fails++; $display("FAIL err1 got %b exp 101", {def_active, def_hreadyout, def_hresp}); end
    checks++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL err1_cnt got %0d exp 1", err_cnt); end
    step();
    checks++; if ({def_active, def_hreadyout, def_hresp} !== 3'b111) begin fails++; $display("FAIL err2 got %b exp 111", {def_active, def_hreadyout, def_hresp}); end
    step();
    checks++; if (resp_sel !== 2'b01 || def_active !== 1'b0 || def_hresp !== 1'b0) begin fails++; $display("FAIL after_err got %b/%b/%b exp 01/0/0", resp_sel, def_active, def_hresp); end
    checks++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL after_err_cnt got %0d exp 1", err_cnt); end
  endtask

  task automatic test_back_to_back();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL clr got %0d exp 0", err_cnt); end
    HADDR = 32'h2000_0000; HTRANS = 2'b10;
    step();
    HADDR = 32'h2000_0004;
    checks++; if ({def_hreadyout, def_hresp} !== 2'b01) begin fails++; $display("FAIL b2b_err1a got %b exp 01", {def_hreadyout, def_hresp}); end
    step();
    checks++; if ({def_hreadyout, def_hresp} !== 2'b11) begin fails++; $display("FAIL b2b_err2a got %b exp 11", {def_hreadyout, def_hresp}); end
    step();
    HADDR = 32'h0000_0000;
    checks++; if ({def_hreadyout, def_hresp} !== 2'b01) begin fails++; $display("FAIL b2b_err1b got %b exp 01", {def_hreadyout, def_hresp}); end
    step();
    checks++; if ({def_hreadyout, def_hresp} !== 2'b11) begin fails++; $display("FAIL b2b_err2b got %b exp 11", {def_hreadyout, def_hresp}); end
    checks++; if (err_cnt !== 8'd2) begin fails++; $display("FAIL b2b_cnt got %0d exp 2", err_cnt); end
    step();
    HTRANS = 2'b00;
    checks++; if (resp_sel !== 2'b01 || def_active !== 1'b0) begin fails++; $display("FAIL b2b_map got %b/%b exp 01/0", resp_sel, def_active); end
    checks++; if ({def_hreadyout, def_hresp} !== 2'b10) begin fails++; $display("FAIL b2b_ok got %b exp 10", {def_hreadyout, def_hresp}); end
    step();
  endtask

  task automatic test_counter();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    HADDR = 32'h2000_0000; HTRANS = 2'b10;
    for (int i = 1; i <= 512; i++) begin
      step();
      if (i == 509) begin
        checks++; if (err_cnt !== 8'd255) begin fails++; $display("FAIL cnt_255 got %0d exp 255", err_cnt); end
      end
    end
    checks++; if (err_cnt !== 8'd255 || def_hresp !== 1'b1 || def_hreadyout !== 1'b1) begin fails++; $display("FAIL cnt_sat got %0d/%b%b exp 255/11", err_cnt, def_hreadyout, def_hresp); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL clr_prio got %0d exp 0", err_cnt); end
    checks++; if ({def_hreadyout, def_hresp} !== 2'b01) begin fails++; $display("FAIL clr_err1 got %b exp 01", {def_hreadyout, def_hresp}); end
  endtask

  task automatic test_reset_mid_error();
    HTRANS = 2'b00;
    #2;
    HRESETn = 1'b0;
    #1;
    checks++; if ({def_hreadyout, def_hresp} !== 2'b10) begin fails++; $display("FAIL rst_mid_err got %b exp 10", {def_hreadyout, def_hresp}); end
    checks++; if (def_active !== 1'b0 || resp_sel !== 2'b00) begin fails++; $display("FAIL rst_mid_sel got %b/%b exp 0/00", def_active, resp_sel); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();
    checks++; if ({def_hreadyout, def_hresp} !== 2'b10) begin fails++; $display("FAIL post_rst got %b exp 10", {def_hreadyout, def_hresp}); end
  endtask

  initial begin
    test_reset();
    test_mapped_stall();
    test_unmapped();
    test_back_to_back();
    test_counter();
    test_reset_mid_error();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
